// File: rtl/fetch_pc_unit_pkg.sv
// Shared fetch types: next-PC source select and fetch FSM state.
// FETCH_MISALIGN_TRAP_EN adds the FAULT state used for misaligned branch targets.
package fetch_pc_unit_pkg;

    typedef enum logic {
        PC_INPUT_PC_PLUS_4 = 1'b0,
        PC_INPUT_ALU       = 1'b1
    } pc_input_sel_t;

    typedef enum logic [1:0] {
        ST_REQ   = 2'd0,
        ST_WAIT  = 2'd1,
`ifdef FETCH_MISALIGN_TRAP_EN
        ST_HOLD  = 2'd2,
        ST_FAULT = 2'd3
`else
        ST_HOLD  = 2'd2
`endif
    } fetch_state_t;

    localparam logic [31:0] PC_STEP = 32'd4;

endpackage

// File: rtl/fetch_pc_unit_if.sv
// Fetch bus: instruction-memory request/response plus the decode-side handshake.
// master = fetch unit, slave = memory/decode environment.
interface fetch_pc_unit_if;
    import fetch_pc_unit_pkg::*;

    logic          imem_req_valid;
    logic [31:0]   imem_req_addr;
    logic          imem_req_ready;
    logic          imem_rsp_valid;
    logic [31:0]   imem_rsp_data;
    logic          instr_valid;
    logic [31:0]   instr;
    logic [31:0]   instr_pc;
    logic          instr_ready;
    pc_input_sel_t pc_input_sel;
    logic [31:0]   alu_result;

    modport master (
        output imem_req_valid, imem_req_addr,
        input  imem_req_ready, imem_rsp_valid, imem_rsp_data,
        output instr_valid, instr, instr_pc,
        input  instr_ready, pc_input_sel, alu_result
    );

    modport slave (
        input  imem_req_valid, imem_req_addr,
        output imem_req_ready, imem_rsp_valid, imem_rsp_data,
        input  instr_valid, instr, instr_pc,
        output instr_ready, pc_input_sel, alu_result
    );

endinterface

// File: rtl/fetch_next_pc.sv
// Combinational next-PC selection and alignment; shared with any future prefetcher.
// With FETCH_MISALIGN_TRAP_EN a bit-1 target is flagged instead of being masked.
module fetch_next_pc
    import fetch_pc_unit_pkg::*;
(
    input  logic [31:0]   pc_i,
    input  pc_input_sel_t sel_i,
    input  logic [31:0]   alu_result_i,
`ifdef FETCH_MISALIGN_TRAP_EN
    output logic          misaligned_o,
`endif
    output logic [31:0]   next_pc_o
);

    logic [31:0] raw_next;

    // Jump targets always drop bit 0; pc+4 wraps naturally in 32 bits.
    assign raw_next = (sel_i == PC_INPUT_ALU) ? (alu_result_i & 32'hFFFF_FFFE)
                                              : (pc_i + PC_STEP);

`ifdef FETCH_MISALIGN_TRAP_EN
    assign next_pc_o    = raw_next;
    assign misaligned_o = raw_next[1];
`else
    assign next_pc_o    = raw_next & 32'hFFFF_FFFC;
`endif

endmodule

// File: rtl/fetch_pc_unit.sv
// Program counter and single-outstanding instruction fetch with decode handshake.
// Optional FETCH_MISALIGN_TRAP_EN: misaligned targets park the unit in FAULT until reset.
module fetch_pc_unit
    import fetch_pc_unit_pkg::*;
#(
    parameter logic [31:0] RESET_VECTOR = 32'h0000_0000
) (
    input  logic             clk,
    input  logic             reset,
`ifdef FETCH_MISALIGN_TRAP_EN
    output logic             misalign_fault,
`endif
    fetch_pc_unit_if.master  bus
);

    fetch_state_t state_q, state_d;
    logic [31:0]  pc_q, pc_d;
    logic [31:0]  instr_q, instr_d;
    logic [31:0]  instr_pc_q, instr_pc_d;
    logic [31:0]  next_pc;
`ifdef FETCH_MISALIGN_TRAP_EN
    logic         next_misaligned;
`endif

    fetch_next_pc u_next_pc (
        .pc_i         (pc_q),
        .sel_i        (bus.pc_input_sel),
        .alu_result_i (bus.alu_result),
`ifdef FETCH_MISALIGN_TRAP_EN
        .misaligned_o (next_misaligned),
`endif
        .next_pc_o    (next_pc)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= ST_REQ;
            pc_q       <= RESET_VECTOR;
            instr_q    <= '0;
            instr_pc_q <= '0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            instr_q    <= instr_d;
            instr_pc_q <= instr_pc_d;
        end
    end

    // Responses are only taken in WAIT, so one arriving alongside request
    // acceptance (still in REQ) or after a reset abort is dropped.
    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        instr_d    = instr_q;
        instr_pc_d = instr_pc_q;
        case (state_q)
            ST_REQ: begin
                if (bus.imem_req_ready) state_d = ST_WAIT;
            end
            ST_WAIT: begin
                if (bus.imem_rsp_valid) begin
                    instr_d    = bus.imem_rsp_data;
                    instr_pc_d = pc_q;
                    state_d    = ST_HOLD;
                end
            end
            ST_HOLD: begin
                if (bus.instr_ready) begin
                    pc_d    = next_pc;
`ifdef FETCH_MISALIGN_TRAP_EN
                    state_d = next_misaligned ? ST_FAULT : ST_REQ;
`else
                    state_d = ST_REQ;
`endif
                end
            end
`ifdef FETCH_MISALIGN_TRAP_EN
            ST_FAULT: state_d = ST_FAULT;
`endif
            default: state_d = ST_REQ;
        endcase
    end

    assign bus.imem_req_valid = (state_q == ST_REQ);
    assign bus.imem_req_addr  = pc_q;
    assign bus.instr_valid    = (state_q == ST_HOLD);
    assign bus.instr          = instr_q;
    assign bus.instr_pc       = instr_pc_q;
`ifdef FETCH_MISALIGN_TRAP_EN
    assign misalign_fault     = (state_q == ST_FAULT);
`endif

endmodule

// File: tb/tb_fetch_pc_unit.sv
// Directed bench for fetch_pc_unit; memory returns addr ^ 32'hC0DE_0000 as the instruction word.
module tb_fetch_pc_unit;
    import fetch_pc_unit_pkg::*;

    localparam logic [31:0] RV  = 32'h0000_0100;
    localparam logic [31:0] KEY = 32'hC0DE_0000;

    logic clk = 1'b0;
    logic reset;
    int   total = 0;
    int   bad   = 0;
`ifdef FETCH_MISALIGN_TRAP_EN
    logic misalign_fault;
`endif

    fetch_pc_unit_if bus ();

    fetch_pc_unit #(.RESET_VECTOR(RV)) dut (
        .clk            (clk),
        .reset          (reset),
`ifdef FETCH_MISALIGN_TRAP_EN
        .misalign_fault (misalign_fault),
`endif
        .bus            (bus)
    );

    always #5 clk = ~clk;

    assign bus.imem_rsp_data = bus.imem_req_addr ^ KEY;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk_req(input string tag, input logic [31:0] addr);
        chk({tag, ".req_valid"}, {31'd0, bus.imem_req_valid}, 32'd1);
        chk({tag, ".req_addr"}, bus.imem_req_addr, addr);
        chk({tag, ".instr_valid"}, {31'd0, bus.instr_valid}, 32'd0);
    endtask

    task automatic chk_hold(input string tag, input logic [31:0] ipc);
        chk({tag, ".instr_valid"}, {31'd0, bus.instr_valid}, 32'd1);
        chk({tag, ".req_valid"}, {31'd0, bus.imem_req_valid}, 32'd0);
        chk({tag, ".instr_pc"}, bus.instr_pc, ipc);
        chk({tag, ".instr"}, bus.instr, ipc ^ KEY);
    endtask

    task automatic chk_wait(input string tag);
        chk({tag, ".req_valid"}, {31'd0, bus.imem_req_valid}, 32'd0);
        chk({tag, ".instr_valid"}, {31'd0, bus.instr_valid}, 32'd0);
    endtask

    initial begin
        reset                = 1'b1;
        bus.imem_req_ready   = 1'b1;
        bus.imem_rsp_valid   = 1'b1;
        bus.instr_ready      = 1'b1;
        bus.pc_input_sel     = PC_INPUT_PC_PLUS_4;
        bus.alu_result       = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        #1;

        // Reset state and back-to-back 3-cycle fetches
        chk_req("rst", RV);
        chk("rst.instr", bus.instr, 32'd0);
        chk("rst.instr_pc", bus.instr_pc, 32'd0);
`ifdef FETCH_MISALIGN_TRAP_EN
        chk("rst.fault", {31'd0, misalign_fault}, 32'd0);
`endif
        tick(1); chk_wait("f0.wait");
        tick(1); chk_hold("f0.hold", RV);
        tick(1); chk_req("f1", RV + 32'd4);
        tick(2); chk_hold("f1.hold", RV + 32'd4);
        tick(1); chk_req("f2", RV + 32'd8);

        // Request stalled 4 cycles; response meanwhile must be ignored
        bus.imem_req_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick(1); chk_req("stall", 32'h0000_0108);
        end
        bus.imem_req_ready = 1'b1;
        bus.imem_rsp_valid = 1'b0;
        tick(1); chk_wait("w0");
        tick(1); chk_wait("w1");
        bus.imem_rsp_valid = 1'b1;
        bus.instr_ready    = 1'b0;
        tick(1); chk_hold("h0", 32'h0000_0108);

        // Decode back-pressure for 5 cycles
        for (int i = 0; i < 5; i++) begin
            tick(1); chk_hold("bp", 32'h0000_0108);
        end
        bus.pc_input_sel = PC_INPUT_ALU;
        bus.alu_result   = 32'h0000_2003;
        bus.instr_ready  = 1'b1;
        tick(1);
`ifdef FETCH_MISALIGN_TRAP_EN
        chk("mis.req_valid", {31'd0, bus.imem_req_valid}, 32'd0);
        chk("mis.instr_valid", {31'd0, bus.instr_valid}, 32'd0);
        chk("mis.fault", {31'd0, misalign_fault}, 32'd1);
        tick(3);
        chk("mis.sticky", {31'd0, misalign_fault}, 32'd1);
        chk("mis.req_valid2", {31'd0, bus.imem_req_valid}, 32'd0);
        reset = 1'b1;
        #2;
        reset = 1'b0;
        #1;
        chk("mis.clr", {31'd0, misalign_fault}, 32'd0);
        chk_req("mis.rst", RV);
`else
        chk_req("mis", 32'h0000_2000);
`endif

        // Wrap pc+4 at the top of the address space
        bus.alu_result = 32'hFFFF_FFFC;
        tick(3); chk_req("top", 32'hFFFF_FFFC);
        bus.pc_input_sel = PC_INPUT_PC_PLUS_4;
        tick(2); chk_hold("top.hold", 32'hFFFF_FFFC);
        tick(1); chk_req("wrap", 32'h0000_0000);

        // Bit 0 of a jump target is cleared without faulting
        bus.pc_input_sel = PC_INPUT_ALU;
        bus.alu_result   = 32'h0000_0041;
        tick(3); chk_req("b0", 32'h0000_0040);
`ifdef FETCH_MISALIGN_TRAP_EN
        chk("b0.fault", {31'd0, misalign_fault}, 32'd0);
`endif

        // Reset in WAIT; the stale response lands in REQ and is dropped
        bus.imem_rsp_valid = 1'b0;
        tick(1); chk_wait("ab.wait");
        reset = 1'b1;
        #1;
        chk_req("ab.rst", RV);
        chk("ab.instr", bus.instr, 32'd0);
        bus.imem_req_ready = 1'b0;
        tick(1);
        @(negedge clk);
        reset = 1'b0;
        tick(2);
        bus.imem_rsp_valid = 1'b1;
        tick(1); chk_req("ab.drop", RV);
        chk("ab.instr_pc", bus.instr_pc, 32'd0);
        bus.imem_rsp_valid = 1'b0;
        bus.imem_req_ready = 1'b1;
        tick(1); chk_wait("ab.w0");
        tick(1); chk_wait("ab.w1");
        bus.imem_rsp_valid = 1'b1;
        tick(1); chk_hold("ab.hold", RV);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/fetch_pc_unit.md
# fetch_pc_unit

Holds the architectural program counter and fetches one instruction at a time from instruction memory, presenting it to decode with a valid/ready handshake. Sits directly downstream of decode's next-PC selection: on the accept cycle it consumes `pc_input_sel` and the ALU result to form the next PC, then issues the next fetch. Single outstanding request; no prediction.

## Interface
- `RESET_VECTOR`, default 32'h0000_0000: PC loaded on reset; bits [1:0] are 0.
- `clk`  in  1  clock; all state updates on rising edge.
- `reset`  in  1  asynchronous, active-high; clears all state immediately.
- `pc_input_sel`  in  pc_input_sel_t  next-PC source; sampled only on the accept cycle.
- `alu_result`  in  32  branch/jump target; sampled only on the accept cycle.
- `imem_req_valid`  out  1  fetch request valid.
- `imem_req_addr`  out  32  fetch address; equals `pc` while `imem_req_valid`.
- `imem_req_ready`  in  1  memory accepts request.
- `imem_rsp_valid`  in  1  instruction word returned.
- `imem_rsp_data`  in  32  instruction word.
- `instr_valid`  out  1  `instr`/`instr_pc` hold a fetched instruction.
- `instr`  out  32  fetched instruction.
- `instr_pc`  out  32  address of `instr`.
- `instr_ready`  in  1  decode accepts `instr` and drives a resolved `pc_input_sel`/`alu_result` this cycle.
- `misalign_fault`  out  1  sticky misaligned-target flag (present only with `FETCH_MISALIGN_TRAP_EN`).

## Operation
- States: REQ, WAIT, HOLD, FAULT (FAULT only with the macro).
- REQ: `imem_req_valid`=1, `imem_req_addr`=pc. `imem_req_ready`=1 -> WAIT; otherwise stay, address stable.
- WAIT: `imem_rsp_valid`=1 -> capture `imem_rsp_data` into `instr`, `instr_pc`<=pc, -> HOLD. `imem_rsp_valid` in same cycle as the request acceptance is ignored (response must come at least one cycle later).
- HOLD: `instr_valid`=1, `instr`/`instr_pc` stable. On `instr_ready`=1 (accept): next = (`pc_input_sel`==PC_INPUT_ALU) ? {`alu_result`[31:1],1'b0} : pc+4; pc<=next; -> REQ.
- `imem_rsp_valid` outside WAIT is ignored; `instr_ready` outside HOLD is ignored.
- pc+4 wraps modulo 2^32: 32'hFFFF_FFFC -> 32'h0000_0000.
- next[1]=1 (misaligned target) handling per Configuration.

## Timing
- Reset value: state REQ, pc=`RESET_VECTOR`, `instr`=0, `instr_pc`=0, `instr_valid`=0, `misalign_fault`=0; `imem_req_valid`=1 from the first cycle after reset deasserts (combinational from state).
- Outputs `imem_req_valid`, `imem_req_addr`, `instr_valid` are decoded from registered state only; no combinational path from any input.
- Minimum throughput: 3 cycles per instruction (REQ, WAIT with immediate response, HOLD with immediate accept).
- Accept -> next `imem_req_valid`: 1 cycle, carrying the new PC.
- Reset mid-operation (any state): returns to REQ at `RESET_VECTOR`; a response to the aborted request arriving later in REQ is dropped; if it arrives in the new WAIT before the new response, it is taken (memory must not return stale responses across reset).

## Configuration
- `FETCH_MISALIGN_TRAP_EN` defined: accept with next[1]=1 -> pc<=next, state FAULT; FAULT holds `imem_req_valid`=0, `instr_valid`=0, `misalign_fault`=1 until reset.
- Undefined: next[1:0] forced to 2'b00, no FAULT state, no `misalign_fault` port.

## Structure
- Shared package (instructions.sv): `pc_input_sel_t`, `PC_INPUT_ALU`, `PC_INPUT_PC_PLUS_4`, new `fetch_state_t` enum.
- One sub-module `fetch_next_pc`: combinational next-PC/alignment computation, reused by any future prefetcher.

## Test plan
- Reset with `RESET_VECTOR`=32'h0000_0100, ready/rsp immediate, `instr_ready`=1, sel PC+4 -> requests at 0x100, 0x104, 0x108 every 3 cycles.
- `imem_req_ready` low 4 cycles in REQ -> `imem_req_addr` stable at pc, no state change; response before acceptance ignored.
- HOLD with `instr_ready` low 5 cycles -> `instr`/`instr_pc` stable; then accept with sel ALU, `alu_result`=32'h0000_2003 -> next request 32'h0000_2002 handled per macro (FAULT, `misalign_fault`=1 with macro; 0x2000 without).
- pc=32'hFFFF_FFFC, accept with PC+4 -> next request at 32'h0000_0000.
- Assert `reset` in WAIT, deliver the old response 2 cycles after release while in REQ -> dropped; fetch restarts at `RESET_VECTOR`, `instr_valid`=0.
- Accept with sel ALU, `alu_result`=32'h0000_0041 -> next request 32'h0000_0040 (bit 0 cleared, no fault).
